// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter: small input FIFO feeding an 8N1 serializer
// with optional even parity, back-to-back frames when bytes are queued.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_tx;

  state_t        w_state;
  logic [BW-1:0] w_baud;
  logic [2:0]    w_bit;
  logic [7:0]    w_shift;
  logic          w_par;
  logic          w_tx;
  logic          w_load;
  logic          w_bit_end;

  // in_ready comes from the registered count only; a pop never
  // reopens the FIFO in the same cycle.
  assign in_ready   = (r_count < DEPTH_C);
  assign w_push     = in_valid && in_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_bit_end = (r_baud == BAUD_MAX);

  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_par   = r_par;
    w_tx    = r_tx;
    w_load  = 1'b0;
    w_pop   = 1'b0;
    if (r_state == S_IDLE || w_bit_end) begin
      w_baud = '0;
    end else begin
      w_baud = r_baud + BW'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (r_count != '0) begin
          w_load = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state = S_DATA;
          w_bit   = 3'd0;
          w_tx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            if (PARITY_EN != 0) begin
              w_state = S_PARITY;
              w_tx    = r_par;
            end else begin
              w_state = S_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit   = r_bit + 3'd1;
            w_shift = {1'b0, r_shift[7:1]};
            w_tx    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state = S_STOP;
          w_tx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_count != '0) begin
            w_load = 1'b1;
          end else begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
    endcase

    // Same load path from IDLE and from the last stop cycle, so
    // queued bytes follow with no idle gap.
    if (w_load) begin
      w_pop   = 1'b1;
      w_state = S_START;
      w_shift = w_head;
      w_par   = ^w_head;
      w_tx    = 1'b0;
      w_baud  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_tx    <= w_tx;
    end
  end

  assign tx      = r_tx;
  assign busy    = (r_state != S_IDLE);
  assign tx_done = (r_state == S_STOP) && w_bit_end;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: two instances (no parity / even parity) checked
// every cycle against a frame-level model, plus literal spot checks.
module tb_uart_byte_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       chk_en = 1'b0;

  logic [1:0] tx_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] rdy_w;
  logic [2:0] cnt0;
  logic [2:0] cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 if (clk_en) clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .tx_done(done_w[0]), .fifo_count(cnt0)
  );

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .tx_done(done_w[1]), .fifo_count(cnt1)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: queue of pending bytes, current frame as a bit
  // vector and a cycle index inside that frame (-1 when idle).
  logic [7:0]  mq0[$];
  logic [7:0]  mq1[$];
  int          mt[2] = '{-1, -1};
  logic [10:0] mbits[2];

  function automatic int flen(int d);
    return (d == 1 ? 11 : 10) * CPB;
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [10:0] frame(logic [7:0] b, int d);
    logic [10:0] f;
    f = '0;
    f[0] = 1'b0;
    f[8:1] = b;
    if (d == 1) begin
      f[9] = ^b;
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mt[0] = -1;
    mt[1] = -1;
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      bit acc;
      bit st;
      logic [7:0] b;
      n = q_size(d);
      acc = in_valid && (n < DEPTH);
      st = 1'b0;
      if (mt[d] < 0) begin
        st = (n > 0);
      end else if (mt[d] == flen(d) - 1) begin
        if (n > 0) st = 1'b1;
        else mt[d] = -1;
      end else begin
        mt[d]++;
      end
      if (st) begin
        b = (d == 0) ? mq0.pop_front() : mq1.pop_front();
        mbits[d] = frame(b, d);
        mt[d] = 0;
      end
      if (acc) begin
        if (d == 0) mq0.push_back(in_data);
        else mq1.push_back(in_data);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int d = 0; d < 2; d++) begin
        logic etx;
        int n;
        etx = (mt[d] < 0) ? 1'b1 : mbits[d][mt[d] / CPB];
        n = q_size(d);
        check($sformatf("tx%0d", d), tx_w[d], etx);
        check($sformatf("busy%0d", d), busy_w[d], mt[d] >= 0);
        check($sformatf("done%0d", d), done_w[d], mt[d] == flen(d) - 1);
        check($sformatf("ready%0d", d), rdy_w[d], n < DEPTH);
        check($sformatf("count%0d", d), (d == 0) ? cnt0 : cnt1, n);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_w != 2'b00 || cnt0 != 0 || cnt1 != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", k < 2000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [9:0] s;
    int bc;

    // Reset with the clock stopped: outputs must settle immediately.
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tx%0d", d), tx_w[d], 1);
      check($sformatf("rst_ready%0d", d), rdy_w[d], 1);
      check($sformatf("rst_busy%0d", d), busy_w[d], 0);
      check($sformatf("rst_done%0d", d), done_w[d], 0);
    end
    check("rst_count0", cnt0, 0);
    check("rst_count1", cnt1, 0);
    #4 rst = 1'b0;
    #2 clk_en = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5.
    push_byte(8'hA5);
    check("a5_pre", tx_w[0], 1);
    s = '0;
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      if (j == 1) check("a5_latency", tx_w[0], 0);
      if (j % CPB == 2 && j <= 40) s[(j - 1) / CPB] = tx_w[0];
      if (j == 39) check("a5_done39", done_w[0], 0);
      if (j == 40) check("a5_done40", done_w[0], 1);
      if (j == 41) check("a5_busy41", busy_w[0], 0);
      if (j == 38) check("a5_parity", tx_w[1], 0);
      if (j == 44) check("a5_par_done44", done_w[1], 1);
    end
    check("a5_frame", s, 10'h34A);
    wait_idle();

    // Parity frames.
    push_byte(8'h07);
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      if (j == 38) check("p07_parity", tx_w[1], 1);
      if (j == 43) check("p07_done43", done_w[1], 0);
      if (j == 44) check("p07_done44", done_w[1], 1);
    end
    wait_idle();
    push_byte(8'h03);
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      if (j == 38) check("p03_parity", tx_w[1], 0);
    end
    wait_idle();

    // Back-to-back bytes on consecutive cycles.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_count", cnt0, 2);
    bc = 1;
    for (int k = 0; k < 400 && busy_w[0]; k++) begin
      bc++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", bc, 120);
    wait_idle();

    // Fill the FIFO while a frame is in flight, then keep offering.
    @(negedge clk);
    in_valid = 1'b1;
    repeat (10) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    check("full_count0", cnt0, 4);
    check("full_ready0", rdy_w[0], 0);
    check("full_busy0", busy_w[0], 1);
    check("full_count1", cnt1, 4);
    repeat (30) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset during bit 3 of 0x55 with two bytes queued.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_bit3", tx_w[0], 0);
    check("mid_queued", cnt0, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx0", tx_w[0], 1);
    check("mid_rst_tx1", tx_w[1], 1);
    check("mid_rst_count0", cnt0, 0);
    check("mid_rst_busy0", busy_w[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    push_byte(8'h81);
    s = '0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j % CPB == 2) s[(j - 1) / CPB] = tx_w[0];
    end
    check("r81_frame", s, 10'h302);
    wait_idle();

    // Random traffic.
    repeat (1500) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
